bus_txn_ctrl: RTL and testbench

Control-side initiator for the shared 8-bit data bus. It accepts a transfer command, drives the header packet on the bus as control ID 2'b11, releases the bus for the source endpoint's grant window, counts payload beats, then pulses `ack` to close the transaction. It sits beside the per-module bus endpoints and is the only block that opens or closes a bus transaction.

---
 rtl/bus_pkg.sv | 37 +++
 rtl/txn_timer.sv | 29 ++
 rtl/bus_txn_ctrl.sv | 143 ++++++++++++++
 tb/tb_bus_txn_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the control-side bus initiator: controller ID,
// header layout, status codes and transaction states.
package bus_pkg;

    localparam logic [1:0] CTRL_ID = 2'b11;

    // Header byte layout; bits [7:6] are always zero.
    localparam int HDR_OP_LSB   = 0;
    localparam int HDR_SRC_LSB  = 2;
    localparam int HDR_DEST_LSB = 4;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_TIMEOUT = 2'b01,
        ERR_REJECT  = 2'b10
    } err_e;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        GAP,
        XFER,
        ACK
    } state_e;

    function automatic logic [7:0] make_header(input logic [1:0] dest,
                                               input logic [1:0] src,
                                               input logic [1:0] op);
        logic [7:0] h;
        h = '0;
        h[HDR_DEST_LSB +: 2] = dest;
        h[HDR_SRC_LSB  +: 2] = src;
        h[HDR_OP_LSB   +: 2] = op;
        return h;
    endfunction

endpackage

// File: rtl/txn_timer.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module txn_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/bus_txn_ctrl.sv
// Control-side bus initiator: sends the header, waits out the grant gap,
// counts payload beats with an idle timeout, and closes with ack/done.
module bus_txn_ctrl
    import bus_pkg::*;
#(
    parameter int GAP_CYCLES = 3,
    parameter int TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_src,
    input  logic [1:0] cmd_dest,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_len,
    inout  wire  [7:0] bus_data,
    inout  wire        bus_valid,
    output logic       ack,
    output logic       busy,
    output logic       done,
    output logic [1:0] err
);

    // Timers count down to zero, so they are loaded with one less than the span.
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] IDLE_LOAD = 8'(TIMEOUT - 1);

    state_e     state, next_state;
    logic [1:0] src_q, dest_q, op_q;
    logic [7:0] len_q, beat_cnt;
    logic       hs, accept, beat;
    logic       gap_load, gap_zero, idle_load, idle_zero;
    logic       ack_d, done_d;
    err_e       err_d;

    txn_timer #(.WIDTH(8)) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .dec      (state == GAP),
        .zero     (gap_zero)
    );

    txn_timer #(.WIDTH(8)) u_idle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (idle_load),
        .load_val (IDLE_LOAD),
        .dec      (state == XFER && !beat),
        .zero     (idle_zero)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        next_state = state;
        hs         = cmd_valid && cmd_ready;
        accept     = 1'b0;
        beat       = 1'b0;
        gap_load   = 1'b0;
        idle_load  = 1'b0;
        done_d     = 1'b0;
        err_d      = ERR_OK;

        case (state)
            IDLE: begin
                if (hs) begin
                    if (cmd_src == CTRL_ID || cmd_src == cmd_dest) begin
                        done_d = 1'b1;
                        err_d  = ERR_REJECT;
                    end else begin
                        accept     = 1'b1;
                        next_state = HDR;
                    end
                end
            end
            HDR: begin
                gap_load   = 1'b1;
                next_state = GAP;
            end
            GAP: begin
                if (gap_zero) begin
                    idle_load  = 1'b1;
                    next_state = (len_q != '0) ? XFER : ACK;
                end
            end
            XFER: begin
                // A beat in the cycle the idle timer expires still counts.
                beat = (bus_valid == 1'b1);
                if (beat) begin
                    idle_load = 1'b1;
                    if (beat_cnt + 8'd1 == len_q) next_state = ACK;
                end else if (idle_zero) begin
                    err_d      = ERR_TIMEOUT;
                    next_state = ACK;
                end
            end
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase

        ack_d = (next_state == ACK);
        if (ack_d) done_d = 1'b1;
    end

    // NOTE: the command fields are reset along with the control state so
    // the header never drives stale values after a mid-transaction reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            ack       <= 1'b0;
            done      <= 1'b0;
            err       <= ERR_OK;
            src_q     <= '0;
            dest_q    <= '0;
            op_q      <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
        end else begin
            state     <= next_state;
            cmd_ready <= (next_state == IDLE);
            ack       <= ack_d;
            done      <= done_d;
            err       <= err_d;
            if (hs) begin
                src_q  <= cmd_src;
                dest_q <= cmd_dest;
                op_q   <= cmd_op;
                len_q  <= cmd_len;
            end
            if (accept) beat_cnt <= '0;
            else if (beat) beat_cnt <= beat_cnt + 8'd1;
        end
    end

    assign busy      = (state != IDLE);
    assign bus_data  = (state == HDR) ? make_header(dest_q, src_q, op_q) : 8'bz;
    assign bus_valid = (state == HDR) ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_bus_txn_ctrl.sv
// Directed bench for bus_txn_ctrl: a table of commands with beat patterns
// and expected close timing, plus reset sequences.
module tb_bus_txn_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_src, cmd_dest, cmd_op;
    logic [7:0] cmd_len;
    tri0  [7:0] bus_data;
    tri0        bus_valid;
    logic       ack, busy, done;
    logic [1:0] err;
    logic       src_drive;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int NLBL = 30;

    // Label k is the cycle right after the k-th edge counting the accept edge
    // as 1, so the header is at label 1 and XFER starts at label 5.
    typedef struct {
        logic [1:0]  src, dest, op;
        logic [7:0]  len;
        logic [31:0] beat_mask;
        logic        reject;
        logic [7:0]  hdr;
        int          done_k;
        logic [1:0]  err;
    } vec_t;

    vec_t vecs[8];

    assign bus_valid = src_drive ? 1'b1 : 1'bz;

    bus_txn_ctrl #(.GAP_CYCLES(3), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_src   (cmd_src),
        .cmd_dest  (cmd_dest),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .bus_data  (bus_data),
        .bus_valid (bus_valid),
        .ack       (ack),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int         done_k, ack_n, done_n, extra_drive;
        logic [1:0] err_at;
        logic       ack_at;
        done_k = -1; ack_n = 0; done_n = 0; extra_drive = 0;
        err_at = 2'b00; ack_at = 1'b0;

        cmd_src = v.src; cmd_dest = v.dest; cmd_op = v.op; cmd_len = v.len;
        cmd_valid = 1'b1;
        for (int k = 1; k < NLBL; k++) begin
            step();
            if (k == 1) cmd_valid = 1'b0;
            src_drive = v.beat_mask[k];
            #1;
            if (k == 1 && !v.reject) begin
                check($sformatf("v%0d header", idx), 32'(bus_data), 32'(v.hdr));
                check($sformatf("v%0d header valid", idx), 32'(bus_valid), 32'd1);
            end
            if (k == 1) check($sformatf("v%0d busy in HDR", idx), 32'(busy), 32'(!v.reject));
            if ((k != 1 || v.reject) && (bus_data !== 8'h00 || (!src_drive && bus_valid !== 1'b0)))
                extra_drive++;
            if (done === 1'b1) begin
                done_n++;
                if (done_k < 0) begin
                    done_k = k;
                    err_at = err;
                    ack_at = ack;
                end
            end
            if (ack === 1'b1) ack_n++;
            if (k == v.done_k + 1) begin
                check($sformatf("v%0d ready after close", idx), 32'(cmd_ready), 32'd1);
                check($sformatf("v%0d busy after close", idx), 32'(busy), 32'd0);
            end
        end
        src_drive = 1'b0;

        check($sformatf("v%0d done cycle", idx), 32'(done_k), 32'(v.done_k));
        check($sformatf("v%0d err", idx), 32'(err_at), 32'(v.err));
        check($sformatf("v%0d ack with done", idx), 32'(ack_at), 32'(!v.reject));
        check($sformatf("v%0d ack count", idx), 32'(ack_n), v.reject ? 32'd0 : 32'd1);
        check($sformatf("v%0d done count", idx), 32'(done_n), 32'd1);
        check($sformatf("v%0d stray bus drive", idx), 32'(extra_drive), 32'd0);
    endtask

    initial begin
        int ack_n;

        //          src    dest   op     len    beat_mask      rej   hdr    done  err
        vecs[0] = '{2'b01, 2'b10, 2'b01, 8'd4, 32'h0000_01E0, 1'b0, 8'h25, 9,  2'b00};
        vecs[1] = '{2'b00, 2'b01, 2'b00, 8'd0, 32'h0000_0000, 1'b0, 8'h10, 5,  2'b00};
        // Two beats then silence: close 16 clocks after the edge sampling beat 2.
        vecs[2] = '{2'b10, 2'b00, 2'b10, 8'd3, 32'h0000_0060, 1'b0, 8'h0A, 23, 2'b01};
        vecs[3] = '{2'b10, 2'b10, 2'b11, 8'd2, 32'h0000_0000, 1'b1, 8'h00, 1,  2'b10};
        vecs[4] = '{2'b11, 2'b00, 2'b00, 8'd1, 32'h0000_0000, 1'b1, 8'h00, 1,  2'b10};
        // Stray valid during GAP (labels 2,3) must be ignored.
        vecs[5] = '{2'b01, 2'b00, 2'b11, 8'd2, 32'h0000_006C, 1'b0, 8'h07, 7,  2'b00};
        // Second beat lands in the 16th idle cycle: the beat wins.
        vecs[6] = '{2'b00, 2'b11, 2'b10, 8'd2, 32'h0020_0020, 1'b0, 8'h32, 22, 2'b00};
        // No beats at all: 16 idle XFER cycles then timeout.
        vecs[7] = '{2'b01, 2'b11, 2'b00, 8'd1, 32'h0000_0000, 1'b0, 8'h34, 21, 2'b01};

        rst = 1'b1; cmd_valid = 1'b0; src_drive = 1'b0;
        cmd_src = '0; cmd_dest = '0; cmd_op = '0; cmd_len = '0;

        step();
        step();
        check("reset ready", 32'(cmd_ready), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset ack/done", 32'({ack, done}), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset bus", 32'({bus_valid, bus_data}), 32'd0);
        rst = 1'b0;
        #1;
        check("ready before first edge", 32'(cmd_ready), 32'd0);
        step();
        check("ready after first edge", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset mid-XFER after one of five beats.
        cmd_src = 2'b01; cmd_dest = 2'b10; cmd_op = 2'b01; cmd_len = 8'd5;
        cmd_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            cmd_valid = 1'b0;
            src_drive = (k == 5);
        end
        step();
        src_drive = 1'b0;
        check("mid-xfer busy before reset", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async reset ready", 32'(cmd_ready), 32'd0);
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset ack/done/err", 32'({ack, done, err}), 32'd0);
        check("async reset bus", 32'({bus_valid, bus_data}), 32'd0);
        ack_n = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (ack === 1'b1) ack_n++;
        end
        rst = 1'b0;
        step();
        if (ack === 1'b1) ack_n++;
        check("no ack across reset", 32'(ack_n), 32'd0);
        check("ready after reset release", 32'(cmd_ready), 32'd1);
        run_vec(vecs[0], 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
